// File: rtl/riscv_soft_pkg.sv
// Shared definitions for the riscv-soft register file: default sizes, the
// register-address type and the hardwired-zero register constant.
package riscv_soft_pkg;

    localparam int unsigned XPR_LEN_DEF  = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_AW       = $clog2(NUM_REGS_DEF);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/riscv_soft_regfile_rdport.sv
// One combinational read port: storage mux, x0 zeroing and readiness from the
// busy vector. Optional macro RISCV_SOFT_REGFILE_BYPASS_EN forwards same-cycle
// writeback data, and marks the port ready.
module riscv_soft_regfile_rdport
    import riscv_soft_pkg::*;
#(
    parameter int unsigned XPR_LEN  = XPR_LEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_WR   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]             addr,
`ifdef RISCV_SOFT_REGFILE_BYPASS_EN
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*XPR_LEN-1:0] wr_data,
`endif
    input  logic [XPR_LEN-1:0]        mem [NUM_REGS],
    input  logic [NUM_REGS-1:0]       busy,
    output logic [XPR_LEN-1:0]        data,
    output logic                      ready
);

    // Select stored value; x0 reads as zero and is never pending.
    always_comb begin
        data  = (addr == '0) ? '0 : mem[addr];
        ready = (addr == '0) || !busy[addr];
`ifdef RISCV_SOFT_REGFILE_BYPASS_EN
        // Ascending loop so the highest matching write port wins.
        if (addr != '0) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                    data  = wr_data[j*XPR_LEN +: XPR_LEN];
                    ready = 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/riscv_soft_regfile_sb.sv
// Integer register file with N read / M writeback ports and a write-pending
// scoreboard gating issue of producers onto busy registers.
// Optional macro RISCV_SOFT_REGFILE_BYPASS_EN enables writeback-to-read bypass.
module riscv_soft_regfile_sb
    import riscv_soft_pkg::*;
#(
    parameter int unsigned XPR_LEN  = XPR_LEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*XPR_LEN-1:0] rd_data,
    output logic [NUM_RD-1:0]         rd_ready,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*XPR_LEN-1:0] wr_data,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_addr,
    output logic                      iss_ready,
    output logic [AW:0]               busy_count
);

    logic [XPR_LEN-1:0]  mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_d;
    logic [AW:0]         busy_cnt_d;
    logic                wb_hit;

    // Issue is accepted unless the target is pending and not retiring now.
    always_comb begin
        wb_hit = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == iss_addr)) begin
                wb_hit = 1'b1;
            end
        end
        iss_ready = (iss_addr == '0) || !busy[iss_addr] || wb_hit;
    end

    // Next busy vector: writebacks clear, then an accepted issue sets (set wins).
    always_comb begin
        busy_d = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && iss_ready && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Storage and scoreboard state; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XPR_LEN +: XPR_LEN];
                end
            end
            busy       <= busy_d;
            busy_count <= busy_cnt_d;
        end
    end

    // One read port per rd_addr slot.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        riscv_soft_regfile_rdport #(
            .XPR_LEN  (XPR_LEN),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR)
        ) u_rdport (
            .addr    (rd_addr[i*AW +: AW]),
`ifdef RISCV_SOFT_REGFILE_BYPASS_EN
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
`endif
            .mem     (mem),
            .busy    (busy),
            .data    (rd_data[i*XPR_LEN +: XPR_LEN]),
            .ready   (rd_ready[i])
        );
    end

endmodule

// File: tb/tb_riscv_soft_regfile_sb.sv
// Randomised and directed bench for riscv_soft_regfile_sb with a scoreboard:
// the driver pushes expected outputs, a monitor pops and compares them.
module tb_riscv_soft_regfile_sb;

    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int W   = 32;
    localparam int AW  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*W-1:0]  rd_data;
    logic [NRD-1:0]    rd_ready;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*W-1:0]  wr_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic [AW:0]       busy_count;

    riscv_soft_regfile_sb #(
        .XPR_LEN  (W),
        .NUM_REGS (32),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .iss_ready  (iss_ready),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*W-1:0] rd_data;
        logic [NRD-1:0]   rd_ready;
        logic             iss_ready;
        logic [AW:0]      busy_count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference architectural state.
    logic [W-1:0] m_mem [32];
    bit           m_busy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: outputs are stable between the drive point and the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e.rd_data));
                chk("rd_ready", 64'(rd_ready), 64'(e.rd_ready));
                chk("iss_ready", 64'(iss_ready), 64'(e.iss_ready));
                chk("busy_count", 64'(busy_count), 64'(e.busy_count));
            end
        end
    end

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // One cycle: drive just after the edge, predict outputs, advance the model.
    task automatic step(input bit rst, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input bit iv, input logic [4:0] ia);
        exp_t        e;
        logic [4:0]  ra [2];
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        bit          ir;
        int          cnt;
        @(posedge clk);
        #1;
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;
        reset     = rst;
        rd_addr   = {ra1, ra0};
        wr_en     = we;
        wr_addr   = {wa1, wa0};
        wr_data   = {wd1, wd0};
        iss_valid = iv;
        iss_addr  = ia;
        if (!rst) begin
            model_reset();
            e.rd_data    = '0;
            e.rd_ready   = '1;
            e.iss_ready  = 1'b1;
            e.busy_count = '0;
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < NRD; i++) begin
            logic [31:0] d;
            bit          rdy;
            d   = (ra[i] == 0) ? 32'h0 : m_mem[ra[i]];
            rdy = (ra[i] == 0) || !m_busy[ra[i]];
`ifdef RISCV_SOFT_REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (ra[i] != 0 && we[j] && wa[j] == ra[i]) begin
                    d   = wd[j];
                    rdy = 1'b1;
                end
            end
`endif
            e.rd_data[i*W +: W] = d;
            e.rd_ready[i]       = rdy;
        end
        ir = (ia == 0) || !m_busy[ia] || (we[0] && wa0 == ia) || (we[1] && wa1 == ia);
        cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
        e.iss_ready  = ir;
        e.busy_count = 6'(cnt);
        exp_q.push_back(e);
        // State after this edge.
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wa[j] != 0) begin
                m_mem[wa[j]]  = wd[j];
                m_busy[wa[j]] = 1'b0;
            end
        end
        if (iv && ir && ia != 0) m_busy[ia] = 1'b1;
    endtask

    initial begin
        int wait_cnt;
        reset     = 1'b0;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        model_reset();

        // Reset state, then release.
        step(0, 5, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 5, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        // Issue x7, re-issue while busy.
        step(1, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7);
        step(1, 7, 0, 2'b00, 0, 0, 0, 0, 1, 7);
        // Writeback x7 while reading it.
        step(1, 7, 7, 2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0);
        step(1, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        // Issue and writeback x9 in the same cycle.
        step(1, 9, 0, 2'b01, 9, 32'h1234, 0, 0, 1, 9);
        step(1, 9, 9, 2'b00, 0, 0, 0, 0, 1, 9);
        // Both write ports hit x3; higher port wins.
        step(1, 3, 0, 2'b11, 3, 32'h11, 3, 32'h22, 0, 0);
        step(1, 3, 0, 2'b01, 0, 32'hFF, 0, 0, 0, 0);
        step(1, 0, 3, 2'b00, 0, 0, 0, 0, 1, 0);
        // Issue x4..x6, then reset mid-stream with an issue in flight.
        step(1, 4, 5, 2'b00, 0, 0, 0, 0, 1, 4);
        step(1, 4, 5, 2'b00, 0, 0, 0, 0, 1, 5);
        step(1, 4, 6, 2'b00, 0, 0, 0, 0, 1, 6);
        step(0, 4, 6, 2'b00, 0, 0, 0, 0, 1, 7);
        step(1, 4, 7, 2'b00, 0, 0, 0, 0, 0, 0);

        // Random traffic on a narrow address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) != 0),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 15)), $urandom(),
                 5'($urandom_range(0, 15)), $urandom(),
                 bit'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_soft_regfile_sb.md
# riscv_soft_regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard, the successor to the single-write, two-read regfile in the riscv-soft core. It provides N read ports and M write (writeback) ports. It tracks which architectural registers have an in-flight producer and gates issue of a new producer onto an already-busy register through a valid/ready handshake. Optional same-cycle writeback-to-read bypass lets decode consume results in the cycle they retire.

## Interface
- XPR_LEN, 32, data width of each register
- NUM_REGS, 32, number of architectural registers (power of two, ≥ 2); register 0 hardwired to zero
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, writeback ports (1..2)
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*XPR_LEN  packed read data
- rd_ready  out  NUM_RD  1 = rd_data[i] is architecturally current (no pending producer, or bypassed)
- wr_en  in  NUM_WR  writeback enables
- wr_addr  in  NUM_WR*AW  writeback addresses
- wr_data  in  NUM_WR*XPR_LEN  writeback data
- iss_valid  in  1  issue request: instruction will produce a result into iss_addr
- iss_addr  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle when iss_valid && iss_ready
- busy_count  out  AW+1  number of registers currently marked busy

## Operation
- Storage: NUM_REGS×XPR_LEN flops plus a NUM_REGS busy vector. On reset all registers = 0, all busy = 0.
- Read: combinational. rd_data[i] = 0 when rd_addr[i] == 0, else mem[rd_addr[i]]. rd_ready[i] = !busy[rd_addr[i]]; port reading x0 is always ready.
- Write: on the clock edge, for each j with wr_en[j] and wr_addr[j] != 0, mem[wr_addr[j]] <= wr_data[j] and busy[wr_addr[j]] <= 0. Writes to x0 are dropped and do not affect busy.
- Two write ports to the same address in one cycle: higher port index wins data. Busy is cleared.
- Issue: iss_ready = (iss_addr == 0) || !busy[iss_addr] || (a writeback to iss_addr occurs this cycle). On handshake with iss_addr != 0, busy[iss_addr] <= 1. Issue to x0 is always accepted and sets nothing.
- Same-cycle issue handshake and writeback to the same register: set wins, so busy = 1 afterwards and mem takes wr_data.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- busy_count: registered popcount of the busy vector, updated with it. Reset value 0. Maximum value NUM_REGS-1.
- iss_valid low: iss_ready is still driven per the formula above (no dependency on iss_valid).

## Timing
- Read latency 0 (combinational from rd_addr / state).
- A write becomes visible on rd_data the cycle after the edge unless bypass is compiled in.
- Busy set/clear is visible on rd_ready and iss_ready the cycle after the edge.
- Reset outputs: rd_data = 0 for all ports, rd_ready = all ones, iss_ready = 1, busy_count = 0.
- Reset asserted mid-operation clears all state asynchronously. Any handshake in that cycle is lost.

## Configuration
- RISCV_SOFT_REGFILE_BYPASS_EN defined: when wr_en[j] && wr_addr[j] == rd_addr[i] != 0, rd_data[i] = wr_data[j] (highest j wins) and rd_ready[i] = 1 in the same cycle.
- Undefined: no bypass. Reads return stored values and rd_ready follows the busy vector only. The write-enable path has no combinational route to rd_data.

## Structure
- Shared package riscv_soft_pkg: XPR_LEN and NUM_REGS defaults, a register-address typedef, and the x0 constant.
- One sub-module, riscv_soft_regfile_rdport: a single read port with mux, x0 zeroing, ready logic and optional bypass. It is instantiated NUM_RD times in a generate loop.

## Test plan
- Reset, then read all ports at addr 5 → rd_data = 0, rd_ready = 1, busy_count = 0, iss_ready = 1.
- Issue to x7 (handshake), then rd_addr[0] = 7 next cycle → rd_ready[0] = 0, busy_count = 1. A second issue to x7 sees iss_ready = 0.
- Writeback x7 = 0xDEADBEEF with rd_addr[0] = 7 in the same cycle → with BYPASS_EN: rd_data = 0xDEADBEEF and ready = 1 that cycle. Without it: both take effect next cycle. busy_count returns to 0.
- Issue x9 and writeback x9 = 0x1234 in the same cycle → iss_ready = 1; next cycle busy[9] = 1 and mem[9] = 0x1234.
- NUM_WR = 2, both ports write x3 (0x11 on port 0, 0x22 on port 1) → mem[3] = 0x22. Writeback to x0 = 0xFF → reads of x0 return 0.
- Issue x4, x5, x6, then assert reset mid-stream → busy_count = 0 and all rd_ready = 1 immediately, with no clock needed.
